bitmap_pixel_fetcher: RTL
=========================

Name: bitmap_pixel_fetcher

Overview:
Consumer side of bitmap-mode VRAM addressing. For each scanline of bitmap BG modes (16bpp direct colour, or 8bpp paletted with two frames), it walks x from 0 to hmax. For each pixel it computes the VRAM address, issues a read request with a req/ack handshake, and extracts the pixel from the returned halfword. Pixels are pushed into a small output FIFO with valid/ready toward the BG compositor.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
FRAME1_BASE, 17'h0A000, byte base of second 8bpp frame

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
line_start  input  1  one-cycle pulse: begin fetching line y
y  input  8  scanline number, sampled on line_start
hmax  input  10  last x index (line width - 1), sampled on line_start
bitmap_color  input  1  1 = 16bpp direct, 0 = 8bpp paletted; sampled on line_start
frame  input  1  8bpp frame select; sampled on line_start
vram_req  output  1  read request
vram_addr  output  17  byte address, valid while vram_req=1
vram_ack  input  1  read accepted; vram_rdata valid in the same cycle
vram_rdata  input  16  little-endian halfword at {vram_addr[16:1],1'b0}
pix_valid  output  1  output pixel valid
pix_ready  input  1  consumer accepts pixel
pix_data  output  16  16bpp: {1'b0,bgr555}; 8bpp: {8'h00,palette index}
pix_direct  output  1  1 = pix_data is a colour, 0 = palette index
pix_x  output  8  x of the pixel on pix_data
busy  output  1  high from line_start until line_done
line_done  output  1  one-cycle pulse after the last pixel leaves the FIFO

Behaviour:
- Reset: FSM to IDLE; FIFO emptied; vram_req, pix_valid, busy and line_done all 0; vram_addr, pix_data and pix_x all 0.
- Address, registered per pixel:
  - row = y*(hmax+1), 16-bit, no truncation; max 159*240=38160.
  - pixelno = row + x, 16-bit.
  - offset = bitmap_color ? {pixelno,1'b0} : {1'b0,pixelno}.
  - base = (frame & ~bitmap_color) ? FRAME1_BASE : 0.
  - addr = base + offset, 17-bit, wraps mod 2^17.
- FSM states:
  - IDLE: on line_start, latch inputs, x=0, busy=1, go to REQ. line_start is ignored in every other state.
  - REQ: vram_req=1 only when free FIFO slots >= 1. vram_addr is stable while vram_req is held and not yet acked.
    - On vram_ack, write the pixel into the FIFO.
    - If x==hmax, go to DRAIN; else x++ and recompute the address (1 cycle bubble allowed: vram_req=0 for that cycle).
  - DRAIN: when the FIFO is empty, pulse line_done, clear busy, go to IDLE.
- Pixel extraction:
  - 16bpp: pix_data = {1'b0, vram_rdata[14:0]}; bit 15 is forced to 0.
  - 8bpp: index = addr[0] ? vram_rdata[15:8] : vram_rdata[7:0].
- FIFO:
  - pix_valid = ~empty.
  - A pop occurs when pix_valid & pix_ready.
  - A simultaneous push and pop when full is legal; the fetch engine may count a slot freed by the same-cycle pop.
  - No pixel is ever dropped or duplicated.
- vram_ack while vram_req=0 is a protocol error and is ignored.
- hmax=0: fetch exactly one pixel.
- Latency: first pix_valid no earlier than 2 cycles after line_start with zero-wait ack.

Optional Feature:
PAIR_FETCH_EN:
- When defined, in 8bpp mode one acked halfword yields two pixels (x, x+1), each pushed to the FIFO on consecutive cycles. The request needs 2 free slots. An even x uses both bytes; an odd hmax final pixel is handled naturally, and an even hmax pushes only the low byte for the last x.
- When undefined, there is one request per pixel.
- 16bpp behaviour is identical either way.

Decomposition:
- Package bg_bitmap_pkg:
  - fetch_state_t enum {IDLE,REQ,DRAIN}.
  - FRAME1_BASE_DEFAULT.
  - VRAM_ADDR_W=17, PIX_W=16.
  - A function computing the bitmap address from (x,y,hmax,color,frame).
- One sub-module, bg_pixel_fifo (parameterised depth/width, synchronous, count output); payload {pix_direct,pix_x,pix_data}.

Test Plan:
- 16bpp, y=2, hmax=239, frame=1, pix_ready=1, vram_ack immediate:
  - first vram_addr=17'h003C0 (frame ignored); last =17'h0059E.
  - 240 pixels in x order, then one line_done pulse.
- 8bpp, frame=1, y=0, x=1, rdata=16'hABCD: addr=17'h0A001, pix_data=16'h00AB, pix_direct=0; x=0 gives 16'h00CD.
- Back-pressure with FIFO_DEPTH=4, pix_ready=0 for 20 cycles: exactly 4 acks occur, then vram_req stays 0. Releasing pix_ready resumes with no loss or duplication (scoreboard).
- vram_ack delayed by 3 cycles: vram_addr held constant and vram_req held high until ack. line_start pulsed mid-line: no effect.
- reset asserted mid-line: next cycle busy=0, pix_valid=0, vram_req=0. A new line_start restarts from x=0 correctly.
- With PAIR_FETCH_EN, 8bpp, hmax=159: exactly 80 requests, 160 pixels; hmax=0: 1 request, 1 pixel.

Source files
------------

// File: rtl/bg_bitmap_pkg.sv
// Shared types, widths and the bitmap address helper for the bitmap pixel fetcher.
package bg_bitmap_pkg;

    localparam int VRAM_ADDR_W = 17;
    localparam int PIX_W       = 16;
    localparam logic [VRAM_ADDR_W-1:0] FRAME1_BASE_DEFAULT = 17'h0A000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic             direct;
        logic [7:0]       x;
        logic [PIX_W-1:0] data;
    } pix_word_t;

    // Byte address of pixel x on line y; 16bpp pixels are two bytes wide,
    // 8bpp frame 1 sits at frame1_base. The sum wraps modulo 2^17.
    function automatic logic [VRAM_ADDR_W-1:0] bitmap_addr(
        input logic [9:0]             x,
        input logic [7:0]             y,
        input logic [9:0]             hmax,
        input logic                   color,
        input logic                   frame,
        input logic [VRAM_ADDR_W-1:0] frame1_base
    );
        logic [15:0] width;
        logic [15:0] row;
        logic [15:0] pixelno;
        logic [VRAM_ADDR_W-1:0] offset;
        logic [VRAM_ADDR_W-1:0] base;
        width   = {6'd0, hmax} + 16'd1;
        row     = {8'd0, y} * width;
        pixelno = row + {6'd0, x};
        offset  = color ? {pixelno, 1'b0} : {1'b0, pixelno};
        base    = (frame & ~color) ? frame1_base : '0;
        return base + offset;
    endfunction

endpackage

// File: rtl/bitmap_pixel_fetcher_if.sv
// VRAM read port and pixel output stream of the bitmap pixel fetcher.
interface bitmap_pixel_fetcher_if;
    import bg_bitmap_pkg::*;

    // vram: a read transfers in any cycle with vram_req & vram_ack; vram_addr is held
    // while vram_req waits, vram_rdata is valid in the ack cycle. pix: a pixel moves
    // in any cycle with pix_valid & pix_ready; pix_valid never drops until accepted.
    logic                   vram_req;
    logic [VRAM_ADDR_W-1:0] vram_addr;
    logic                   vram_ack;
    logic [PIX_W-1:0]       vram_rdata;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIX_W-1:0]       pix_data;
    logic                   pix_direct;
    logic [7:0]             pix_x;

    modport master (
        output vram_req, vram_addr, pix_valid, pix_data, pix_direct, pix_x,
        input  vram_ack, vram_rdata, pix_ready
    );

    modport slave (
        input  vram_req, vram_addr, pix_valid, pix_data, pix_direct, pix_x,
        output vram_ack, vram_rdata, pix_ready
    );

endinterface

// File: rtl/bg_pixel_fifo.sv
// Synchronous FIFO for fetched pixels; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module bg_pixel_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 25,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bitmap_pixel_fetcher.sv
// Bitmap BG pixel fetcher: walks one scanline, reads VRAM, queues pixels for the compositor.
// Optional PAIR_FETCH_EN: in 8bpp one halfword read yields two adjacent pixels.
module bitmap_pixel_fetcher
    import bg_bitmap_pkg::*;
#(
    parameter int                     FIFO_DEPTH  = 4,
    parameter logic [VRAM_ADDR_W-1:0] FRAME1_BASE = FRAME1_BASE_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    line_start,
    input  logic [7:0]              y,
    input  logic [9:0]              hmax,
    input  logic                    bitmap_color,
    input  logic                    frame,
    output logic                    busy,
    output logic                    line_done,
    output fetch_state_t            state_dbg,
    bitmap_pixel_fetcher_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t           state_q, state_n;
    logic [9:0]             x_q, x_n, cur_x;
    logic [9:0]             hmax_q, hmax_n;
    logic [7:0]             y_q, y_n;
    logic                   color_q, color_n;
    logic                   frame_q, frame_n;
    logic [VRAM_ADDR_W-1:0] addr_q, addr_n;
    logic                   advance;
    logic                   push, pop, fifo_empty, slot1;
    logic [CW-1:0]          fifo_count;
    logic [7:0]             sel_byte;
    pix_word_t              push_word, pop_word;
`ifdef PAIR_FETCH_EN
    logic                   slot2;
    logic                   pend_q, pend_n;
    logic [7:0]             pend_byte_q, pend_byte_n;
`endif

    bg_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(pix_word_t))) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (push_word),
        .pop     (pop),
        .rd_data (pop_word),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A slot being popped this cycle counts as free for a new request.
    assign pop   = ~fifo_empty & bus.pix_ready;
    assign slot1 = (fifo_count != CW'(FIFO_DEPTH)) | pop;
`ifdef PAIR_FETCH_EN
    assign slot2 = (fifo_count < CW'(FIFO_DEPTH - 1)) |
                   ((fifo_count == CW'(FIFO_DEPTH - 1)) & pop);
`endif
    assign sel_byte = addr_q[0] ? bus.vram_rdata[15:8] : bus.vram_rdata[7:0];

    assign busy           = (state_q != IDLE);
    assign state_dbg      = state_q;
    assign bus.vram_addr  = addr_q;
    assign bus.pix_valid  = ~fifo_empty;
    assign bus.pix_data   = fifo_empty ? '0 : pop_word.data;
    assign bus.pix_x      = fifo_empty ? '0 : pop_word.x;
    assign bus.pix_direct = ~fifo_empty & pop_word.direct;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            hmax_q  <= '0;
            y_q     <= '0;
            color_q <= 1'b0;
            frame_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            hmax_q  <= hmax_n;
            y_q     <= y_n;
            color_q <= color_n;
            frame_q <= frame_n;
            addr_q  <= addr_n;
        end
    end

`ifdef PAIR_FETCH_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
        end else begin
            pend_q      <= pend_n;
            pend_byte_q <= pend_byte_n;
        end
    end
`endif

    always_comb begin
        state_n      = state_q;
        x_n          = x_q;
        hmax_n       = hmax_q;
        y_n          = y_q;
        color_n      = color_q;
        frame_n      = frame_q;
        addr_n       = addr_q;
        advance      = 1'b0;
        cur_x        = x_q;
        bus.vram_req = 1'b0;
        push         = 1'b0;
        line_done    = 1'b0;
        push_word.direct = color_q;
        push_word.x      = x_q[7:0];
        push_word.data   = color_q ? {1'b0, bus.vram_rdata[14:0]} : {8'h00, sel_byte};
`ifdef PAIR_FETCH_EN
        pend_n      = pend_q;
        pend_byte_n = pend_byte_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (line_start) begin
                    y_n     = y;
                    hmax_n  = hmax;
                    color_n = bitmap_color;
                    frame_n = frame;
                    x_n     = '0;
                    addr_n  = bitmap_addr(10'd0, y, hmax, bitmap_color, frame, FRAME1_BASE);
                    state_n = REQ;
                end
            end
            REQ: begin
`ifdef PAIR_FETCH_EN
                if (pend_q) begin
                    // Second pixel of a pair: the odd byte held from the previous ack.
                    push           = 1'b1;
                    cur_x          = x_q + 10'd1;
                    push_word.x    = cur_x[7:0];
                    push_word.data = {8'h00, pend_byte_q};
                    pend_n         = 1'b0;
                    advance        = 1'b1;
                end else begin
                    bus.vram_req = color_q ? slot1 : slot2;
                    if (bus.vram_req && bus.vram_ack) begin
                        push = 1'b1;
                        if (!color_q && (x_q != hmax_q)) begin
                            pend_n      = 1'b1;
                            pend_byte_n = bus.vram_rdata[15:8];
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
`else
                bus.vram_req = slot1;
                if (bus.vram_req && bus.vram_ack) begin
                    push    = 1'b1;
                    advance = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (fifo_empty) begin
                    line_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (advance) begin
            if (cur_x == hmax_q) begin
                state_n = DRAIN;
            end else begin
                x_n    = cur_x + 10'd1;
                addr_n = bitmap_addr(cur_x + 10'd1, y_q, hmax_q, color_q, frame_q, FRAME1_BASE);
            end
        end
    end

endmodule
